// File: rtl/apb_cfg_info_if.sv
// rtl/apb_cfg_info_if.sv - APB-style bus bundle for the configuration/info slave
interface apb_cfg_info_if;
    logic        i_sel;
    logic        i_enable;
    logic [4:0]  i_addr;
    logic        i_write;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic [31:0] o_rdata;
    logic        o_slverr;

    modport slave (
        input  i_sel, i_enable, i_addr, i_write, i_wdata,
        output o_ready, o_rdata, o_slverr
    );

    modport master (
        output i_sel, i_enable, i_addr, i_write, i_wdata,
        input  o_ready, o_rdata, o_slverr
    );
endinterface

// File: rtl/apb_cfg_info.sv
// rtl/apb_cfg_info.sv - APB slave exposing SoC build configuration, FW ID, scratch and cycle counter
module apb_cfg_info #(
    parameter logic [31:0] hw_id             = 32'h20221101,
    parameter int          cpu_num           = 1,
    parameter int          ilog2_nways       = 2,
    parameter int          ilog2_lines       = 7,
    parameter int          dlog2_nways       = 2,
    parameter int          dlog2_lines       = 7,
    parameter int          l2_ena            = 0,
    parameter int          l2_log2_nways     = 4,
    parameter int          l2_log2_lines     = 9,
    parameter int          bootrom_log2_size = 16,
    parameter int          sram_log2_size    = 18,
    parameter int          uart_speedup      = 0
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    apb_cfg_info_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, RESP} state_t;

    localparam logic [31:0] cpu_cfg = {3'b0, 4'(l2_log2_lines), 4'(l2_log2_nways), 1'(l2_ena),
                                       4'(dlog2_lines), 4'(dlog2_nways), 4'(ilog2_lines),
                                       4'(ilog2_nways), 4'(cpu_num)};
    localparam logic [31:0] mem_cfg = {12'b0, 4'(uart_speedup), 8'(sram_log2_size),
                                       8'(bootrom_log2_size)};

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        slverr_q, slverr_d;
    logic [31:0] fw_id_q, fw_id_d;
    logic [31:0] scratch_q, scratch_d;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] snap_hi_q, snap_hi_d;
    logic [31:0] rmux;
    logic        rsv;

    // Low address bits are don't-care so every word alias decodes identically.
    always_comb begin
        rmux = '0;
        rsv  = 1'b0;
        casez (bus.i_addr)
            5'b000??: rmux = hw_id;
            5'b001??: rmux = fw_id_q;
            5'b010??: rmux = cpu_cfg;
            5'b011??: rmux = mem_cfg;
            5'b100??: rmux = cnt_q[31:0];
            5'b101??: rmux = snap_hi_q;
            5'b110??: rmux = scratch_q;
            default:  rsv  = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        fw_id_d   = fw_id_q;
        scratch_d = scratch_q;
        snap_hi_d = snap_hi_q;
        cnt_d     = cnt_q + 64'd1;
        case (state_q)
            IDLE: begin
                if (bus.i_sel && !bus.i_enable) state_d = SETUP;
            end
            SETUP: begin
                if (!bus.i_sel) begin
                    state_d = IDLE;
                end else if (bus.i_enable) begin
                    state_d  = RESP;
                    ready_d  = 1'b1;
                    slverr_d = rsv;
                    rdata_d  = bus.i_write ? 32'd0 : rmux;
                    if (bus.i_write) begin
                        casez (bus.i_addr)
                            5'b001??: fw_id_d   = bus.i_wdata;
                            5'b110??: scratch_d = bus.i_wdata;
                            default:  ;
                        endcase
                    end else if (bus.i_addr[4:2] == 3'd4) begin
                        // Latch the upper word so a following TIME_HI read is coherent with TIME_LO.
                        snap_hi_d = cnt_q[63:32];
                    end
                end
            end
            RESP: begin
                state_d = (bus.i_sel && !bus.i_enable) ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            fw_id_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            snap_hi_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            fw_id_q   <= fw_id_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            snap_hi_q <= snap_hi_d;
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_rdata  = rdata_q;
    assign bus.o_slverr = slverr_q;
endmodule

// File: tb/tb_apb_cfg_info.sv
// tb/tb_apb_cfg_info.sv - directed self-checking bench for apb_cfg_info
module tb_apb_cfg_info;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic        pre_ready, acc_ready, acc_slverr, post_ready;
    logic [31:0] acc_rdata;

    apb_cfg_info_if bus ();

    apb_cfg_info dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic bus_setup(input logic [4:0] a, input logic w, input logic [31:0] d);
        bus.i_sel = 1'b1; bus.i_enable = 1'b0;
        bus.i_addr = a; bus.i_write = w; bus.i_wdata = d;
        @(negedge clk);
        pre_ready = bus.o_ready;
    endtask

    task automatic bus_access();
        bus.i_enable = 1'b1;
        @(negedge clk);
        acc_ready  = bus.o_ready;
        acc_rdata  = bus.o_rdata;
        acc_slverr = bus.o_slverr;
    endtask

    task automatic bus_idle();
        bus.i_sel = 1'b0; bus.i_enable = 1'b0; bus.i_write = 1'b0;
        @(negedge clk);
        post_ready = bus.o_ready;
    endtask

    task automatic xfer(input logic [4:0] a, input logic w, input logic [31:0] d);
        bus_setup(a, w, d);
        bus_access();
        bus_idle();
    endtask

    task automatic test_reset();
        bus.i_sel = 0; bus.i_enable = 0; bus.i_addr = 0; bus.i_write = 0; bus.i_wdata = 0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.o_rdata !== 32'd0 || bus.o_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rdata=%h slverr=%b, required 0/00000000/0",
                     bus.o_ready, bus.o_rdata, bus.o_slverr);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hw_id();
        xfer(5'h00, 1'b0, 32'd0);
        n_checks++;
        if (pre_ready !== 1'b0 || acc_ready !== 1'b1 || post_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_timing: N+1=%b N+2=%b N+3=%b, required 0 1 0", pre_ready, acc_ready, post_ready);
        end
        n_checks++;
        if (acc_rdata !== 32'h20221101 || acc_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL hw_id_read: rdata=%h slverr=%b, required 20221101/0", acc_rdata, acc_slverr);
        end
        n_checks++;
        if (bus.o_rdata !== 32'h20221101) begin
            n_fail++;
            $display("FAIL rdata_hold: rdata=%h, required 20221101", bus.o_rdata);
        end
    endtask

    task automatic test_cfg();
        xfer(5'h08, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'h12872721) begin
            n_fail++;
            $display("FAIL cpu_cfg: rdata=%h, required 12872721", acc_rdata);
        end
        xfer(5'h0F, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'h00001210 || acc_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_cfg: rdata=%h slverr=%b, required 00001210/0", acc_rdata, acc_slverr);
        end
    endtask

    task automatic test_fw_id();
        xfer(5'h04, 1'b1, 32'hDEADBEEF);
        n_checks++;
        if (acc_ready !== 1'b1 || acc_rdata !== 32'd0 || acc_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL fw_id_write: ready=%b rdata=%h slverr=%b, required 1/00000000/0",
                     acc_ready, acc_rdata, acc_slverr);
        end
        xfer(5'h04, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fw_id_read: rdata=%h, required DEADBEEF", acc_rdata);
        end
        xfer(5'h00, 1'b1, 32'd0);
        n_checks++;
        if (acc_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL ro_write_err: slverr=%b, required 0", acc_slverr);
        end
        xfer(5'h00, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'h20221101) begin
            n_fail++;
            $display("FAIL ro_write_ignored: rdata=%h, required 20221101", acc_rdata);
        end
    endtask

    task automatic test_reserved();
        xfer(5'h1C, 1'b0, 32'd0);
        n_checks++;
        if (acc_slverr !== 1'b1 || acc_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rsv_read: slverr=%b rdata=%h, required 1/00000000", acc_slverr, acc_rdata);
        end
        xfer(5'h1C, 1'b1, 32'h12345678);
        n_checks++;
        if (acc_slverr !== 1'b1 || acc_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rsv_write: slverr=%b rdata=%h, required 1/00000000", acc_slverr, acc_rdata);
        end
        xfer(5'h18, 1'b0, 32'd0);
        n_checks++;
        if (acc_slverr !== 1'b0 || acc_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL after_rsv: slverr=%b rdata=%h, required 0/00000000", acc_slverr, acc_rdata);
        end
    endtask

    task automatic test_time();
        bus_setup(5'h10, 1'b0, 32'd0);
        bus.i_enable = 1'b1;
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
        @(posedge clk);
        #1 release dut.cnt_q;
        @(negedge clk);
        acc_rdata = bus.o_rdata;
        bus_idle();
        n_checks++;
        if (acc_rdata !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL time_lo: rdata=%h, required FFFFFFFE", acc_rdata);
        end
        xfer(5'h14, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL time_hi_snapshot: rdata=%h, required 00000000", acc_rdata);
        end
        xfer(5'h10, 1'b0, 32'd0);
        xfer(5'h14, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'd1) begin
            n_fail++;
            $display("FAIL time_hi_carry: rdata=%h, required 00000001", acc_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bus_setup(5'h18, 1'b1, 32'hA5A5_5A5A);
        bus_access();
        bus_setup(5'h18, 1'b0, 32'd0);
        n_checks++;
        if (acc_ready !== 1'b1 || pre_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: ready=%b then %b, required 1 then 0", acc_ready, pre_ready);
        end
        bus_access();
        bus_idle();
        n_checks++;
        if (acc_ready !== 1'b1 || acc_rdata !== 32'hA5A5_5A5A) begin
            n_fail++;
            $display("FAIL b2b_second: ready=%b rdata=%h, required 1/A5A55A5A", acc_ready, acc_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bus_setup(5'h00, 1'b0, 32'd0);
        bus_access();
        nrst = 1'b0;
        #1;
        n_checks++;
        if (acc_ready !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: ready before=%b after=%b rdata=%h, required 1/0/00000000",
                     acc_ready, bus.o_ready, bus.o_rdata);
        end
        bus.i_sel = 1'b0; bus.i_enable = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        xfer(5'h18, 1'b1, 32'h0000_0077);
        bus_setup(5'h18, 1'b1, 32'h0000_0005);
        bus.i_enable = 1'b1;
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if (bus.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_access: ready=%b, required 0", bus.o_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: ready=%b, required 0", bus.o_ready);
        end
        bus.i_sel = 1'b0; bus.i_enable = 1'b0; bus.i_write = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
        xfer(5'h18, 1'b0, 32'd0);
        n_checks++;
        if (acc_ready !== 1'b1 || acc_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL scratch_after_reset: ready=%b rdata=%h, required 1/00000000", acc_ready, acc_rdata);
        end
        xfer(5'h04, 1'b0, 32'd0);
        n_checks++;
        if (acc_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL fw_id_after_reset: rdata=%h, required 00000000", acc_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_hw_id();
        test_cfg();
        test_fw_id();
        test_reserved();
        test_time();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
